snake_body: RTL and testbench
=============================

// Module: snake_body
// PURPOSE
//  Parametrised snake body tracker for the grid game. Holds up to MAX_LEN segment coordinates.
//  Advances the head one cell per step pulse and grows by deferred extension.
//  Rejects 180-degree reversals and detects self/wall collisions.
//  Sits between the direction/input controller and the renderer/food logic.
// PARAMETERS
//  COORD_W  5   bits per coordinate (GRID_W, GRID_H <= 2**COORD_W)
//  MAX_LEN  8   maximum segments including head (>=2)
//  GRID_W   24  columns, legal x = 0..GRID_W-1
//  GRID_H   24  rows, legal y = 0..GRID_H-1
//  INIT_X   12  head x after reset
//  INIT_Y   12  head y after reset
// PORTS
//  clk     in   1                  single clock, all logic on posedge
//  rst     in   1                  synchronous, active-high reset
//  step    in   1                  advance one cell this cycle
//  grow    in   1                  request one extra segment (pulse)
//  dir     in   2                  0 right x+1, 1 down y-1, 2 left x-1, 3 up y+1
//  seg_x   out  MAX_LEN*COORD_W    segment x, seg 0 (head) in LSBs
//  seg_y   out  MAX_LEN*COORD_W    segment y, same packing
//  length  out  clog2(MAX_LEN+1)   valid segment count
//  heading out  2                  direction actually taken last step
//  dead    out  1                  sticky collision flag
// BEHAVIOUR
//  Reset (rst=1 at posedge): seg0=(INIT_X,INIT_Y), other segs 0, length=1, heading=0, dead=0, grow_pend=0. rst has priority over all inputs.
//  States: ALIVE -> DEAD on collision. DEAD holds all outputs frozen until rst; step/grow are ignored.
//  grow: increments grow_pend (saturates at MAX_LEN-length). grow and step in the same cycle: the grow counts toward that step.
//  step in ALIVE:
//   - eff_dir = dir, unless length>1 and dir == heading^2 (reversal); then eff_dir = heading.
//   - next head = seg0 +/- 1 on the eff_dir axis.
//   - Growing when grow_pend>0 and length<MAX_LEN: all segs shift by one index, length+1, grow_pend-1.
//   - Otherwise: shift with the tail dropped, length unchanged.
//   - Segments at index >= length are forced to 0.
//  Latency: outputs reflect the step on the cycle after the step posedge (one register stage).
//  Collision is evaluated combinationally on the next head against segs 1..length-1:
//   - The current tail is excluded when not growing, because it vacates its cell.
//   - The head moving into its own old cell is impossible.
//   - On a hit: dead=1 and segs/length are NOT updated on that step.
//  Arithmetic: next-head math is done in COORD_W+1 bits so that -1 and GRID limits are detectable.
//  Full: length==MAX_LEN; further grow requests are dropped and grow_pend clears.
// CONFIGURATION
//  SNAKE_WRAP_EN defined: edges wrap (x=-1 -> GRID_W-1, x=GRID_W -> 0; same for y). No wall death.
//  SNAKE_WRAP_EN undefined: a head outside the grid sets dead=1 and the body stays frozen, as for self-collision.
// STRUCTURE
//  Package snake_pkg holds:
//   - DIR_RIGHT=0, DIR_DOWN=1, DIR_LEFT=2, DIR_UP=3 constants
//   - dir_t 2-bit typedef
//   - opposite(dir) = dir^2 function
//  Sub-module snake_collide: combinational compare of next head against the segment arrays under a length mask, producing hit.
//  Shift register, grow counter and FSM stay in snake_body.
// TESTING (defaults, wrap off unless stated)
//  1. rst; 3x step dir=0 -> head (15,12), length 1, dead 0, other segs 0.
//  2. grow pulse with step, then 2 steps dir=3 -> length 2 then stays 2; segs (12,14),(12,13).
//  3. length 3 heading right, step dir=2 -> reversal ignored; head x+1, heading stays 0.
//  4. Head (23,5), step dir=0 -> dead=1, head stays (23,5). With SNAKE_WRAP_EN: head (0,5), dead 0.
//  5. length 5 snake turning R,U,L,D into its body -> dead=1 on the step whose next head hits seg1..3. Tail-chasing a length-4 loop -> no death.
//  6. 10 grow pulses at MAX_LEN=8 -> length saturates at 8. rst mid-growth -> length 1, grow_pend 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared direction encoding, FSM state constants and helpers for the snake body tracker.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_RIGHT = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_UP    = 2'd3;

  localparam logic [0:0] ST_ALIVE = 1'b0;
  localparam logic [0:0] ST_DEAD  = 1'b1;

  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'd2;
  endfunction

endpackage

// File: rtl/snake_collide.sv
// Combinational self-collision check: next head against body segments 1..cmp_len-1.
module snake_collide #(
  parameter int COORD_W = 5,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic [COORD_W-1:0]         head_x,
  input  logic [COORD_W-1:0]         head_y,
  input  logic [MAX_LEN*COORD_W-1:0] seg_x,
  input  logic [MAX_LEN*COORD_W-1:0] seg_y,
  input  logic [LEN_W-1:0]           cmp_len,
  output logic                       hit
);

  // Index 0 is the current head, which the new head can never occupy.
  always_comb begin
    hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < cmp_len) &&
          (seg_x[i*COORD_W +: COORD_W] == head_x) &&
          (seg_y[i*COORD_W +: COORD_W] == head_y))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/snake_body.sv
// Snake body tracker: head/segment shift register, deferred growth and collision FSM.
// Define SNAKE_WRAP_EN to make the grid edges wrap instead of killing the snake.
module snake_body
  import snake_pkg::*;
#(
  parameter int COORD_W = 5,
  parameter int MAX_LEN = 8,
  parameter int GRID_W  = 24,
  parameter int GRID_H  = 24,
  parameter int INIT_X  = 12,
  parameter int INIT_Y  = 12,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       step,
  input  logic                       grow,
  input  logic [1:0]                 dir,
  output logic [MAX_LEN*COORD_W-1:0] seg_x,
  output logic [MAX_LEN*COORD_W-1:0] seg_y,
  output logic [LEN_W-1:0]           length,
  output logic [1:0]                 heading,
  output logic                       dead
);

  logic [COORD_W-1:0] seg_x_q [MAX_LEN];
  logic [COORD_W-1:0] seg_y_q [MAX_LEN];
  logic [LEN_W-1:0]   length_q, pend_q, pend_eff, cap, cmp_len, len_next;
  dir_t               heading_q, eff_dir;
  logic [0:0]         state_q;
  logic [COORD_W:0]   nx_raw, ny_raw;
  logic [COORD_W-1:0] nx, ny;
  logic               wall, hit, growing, crash;

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
    assign seg_x[g*COORD_W +: COORD_W] = seg_x_q[g];
    assign seg_y[g*COORD_W +: COORD_W] = seg_y_q[g];
  end

  assign length  = length_q;
  assign heading = heading_q;
  assign dead    = (state_q == ST_DEAD);

  always_comb begin
    eff_dir = dir;
    if ((length_q > LEN_W'(1)) && (dir == opposite(heading_q)))
      eff_dir = heading_q;
  end

  // One extra bit so that -1 and GRID_W/GRID_H are distinguishable from legal cells.
  always_comb begin
    nx_raw = {1'b0, seg_x_q[0]};
    ny_raw = {1'b0, seg_y_q[0]};
    case (eff_dir)
      DIR_RIGHT: nx_raw = nx_raw + (COORD_W+1)'(1);
      DIR_DOWN:  ny_raw = ny_raw - (COORD_W+1)'(1);
      DIR_LEFT:  nx_raw = nx_raw - (COORD_W+1)'(1);
      default:   ny_raw = ny_raw + (COORD_W+1)'(1);
    endcase
  end

`ifdef SNAKE_WRAP_EN
  always_comb begin
    wall = 1'b0;
    nx   = nx_raw[COORD_W-1:0];
    ny   = ny_raw[COORD_W-1:0];
    if (nx_raw == '1)                              nx = COORD_W'(GRID_W - 1);
    else if (nx_raw == (COORD_W+1)'(GRID_W))       nx = '0;
    if (ny_raw == '1)                              ny = COORD_W'(GRID_H - 1);
    else if (ny_raw == (COORD_W+1)'(GRID_H))       ny = '0;
  end
`else
  always_comb begin
    nx   = nx_raw[COORD_W-1:0];
    ny   = ny_raw[COORD_W-1:0];
    wall = (nx_raw >= (COORD_W+1)'(GRID_W)) || (ny_raw >= (COORD_W+1)'(GRID_H));
  end
`endif

  // A grow arriving with a step already counts toward that step.
  always_comb begin
    cap      = LEN_W'(MAX_LEN) - length_q;
    pend_eff = pend_q + LEN_W'(grow);
    if (pend_eff > cap) pend_eff = cap;
    growing  = (pend_eff != '0) && (length_q < LEN_W'(MAX_LEN));
    cmp_len  = growing ? length_q : length_q - LEN_W'(1);
    len_next = growing ? length_q + LEN_W'(1) : length_q;
    crash    = step && (state_q == ST_ALIVE) && (hit || wall);
  end

  snake_collide #(
    .COORD_W (COORD_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_collide (
    .head_x  (nx),
    .head_y  (ny),
    .seg_x   (seg_x),
    .seg_y   (seg_y),
    .cmp_len (cmp_len),
    .hit     (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= '0;
        seg_y_q[i] <= '0;
      end
      seg_x_q[0] <= COORD_W'(INIT_X);
      seg_y_q[0] <= COORD_W'(INIT_Y);
      length_q   <= LEN_W'(1);
      heading_q  <= DIR_RIGHT;
      pend_q     <= '0;
      state_q    <= ST_ALIVE;
    end else if (state_q == ST_ALIVE) begin
      if (crash) begin
        state_q <= ST_DEAD;
      end else if (step) begin
        seg_x_q[0] <= nx;
        seg_y_q[0] <= ny;
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x_q[i] <= (LEN_W'(i) < len_next) ? seg_x_q[i-1] : '0;
          seg_y_q[i] <= (LEN_W'(i) < len_next) ? seg_y_q[i-1] : '0;
        end
        length_q  <= len_next;
        heading_q <= eff_dir;
        pend_q    <= growing ? pend_eff - LEN_W'(1) : pend_eff;
      end else begin
        pend_q <= pend_eff;
      end
    end
  end

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body with default parameters; wrap expectations follow SNAKE_WRAP_EN.
module tb_snake_body;

  logic        clk = 1'b0;
  logic        rst, step, grow;
  logic [1:0]  dir;
  logic [39:0] seg_x, seg_y;
  logic [3:0]  length;
  logic [1:0]  heading;
  logic        dead;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  snake_body dut (
    .clk     (clk),
    .rst     (rst),
    .step    (step),
    .grow    (grow),
    .dir     (dir),
    .seg_x   (seg_x),
    .seg_y   (seg_y),
    .length  (length),
    .heading (heading),
    .dead    (dead)
  );

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; step = 1'b0; grow = 1'b0; dir = 2'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_step(input logic [1:0] d, input logic g);
    step = 1'b1; dir = d; grow = g;
    @(negedge clk);
    step = 1'b0; grow = 1'b0;
  endtask

  task automatic do_grow();
    grow = 1'b1;
    @(negedge clk);
    grow = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [4:0] x, input logic [4:0] y);
    check({tag, "_hx"}, 40'(seg_x[4:0]), 40'(x));
    check({tag, "_hy"}, 40'(seg_y[4:0]), 40'(y));
  endtask

  initial begin
    rst = 1'b0; step = 1'b0; grow = 1'b0; dir = 2'd0;

    // reset state
    do_reset();
    check("rst_segx", seg_x, 40'd12);
    check("rst_segy", seg_y, 40'd12);
    check("rst_len", 40'(length), 40'd1);
    check("rst_head", 40'(heading), 40'd0);
    check("rst_dead", 40'(dead), 40'd0);

    // three steps right, head trace through the expected queue
    exp_q.push_back(5'd13); exp_q.push_back(5'd14); exp_q.push_back(5'd15);
    for (int i = 0; i < 3; i++) begin
      do_step(2'd0, 1'b0);
      check("t1_trace", 40'(seg_x[4:0]), 40'(exp_q.pop_front()));
    end
    check("t1_segx", seg_x, 40'd15);
    check("t1_segy", seg_y, 40'd12);
    check("t1_len", 40'(length), 40'd1);
    check("t1_dead", 40'(dead), 40'd0);

    // deferred grow, then two steps up
    do_reset();
    do_grow();
    check("t2_len_pre", 40'(length), 40'd1);
    do_step(2'd3, 1'b0);
    check("t2_len1", 40'(length), 40'd2);
    check("t2_segy1", seg_y, 40'({5'd12, 5'd13}));
    do_step(2'd3, 1'b0);
    check("t2_len2", 40'(length), 40'd2);
    check("t2_segx", seg_x, 40'({5'd12, 5'd12}));
    check("t2_segy", seg_y, 40'({5'd13, 5'd14}));

    // grow in the same cycle as the step, then reversal at length 3
    do_reset();
    do_step(2'd0, 1'b1);
    check("t3_len2", 40'(length), 40'd2);
    check("t3_segx2", seg_x, 40'({5'd12, 5'd13}));
    do_grow();
    do_step(2'd0, 1'b0);
    check("t3_len3", 40'(length), 40'd3);
    do_step(2'd2, 1'b0);
    check("t3_segx", seg_x, 40'({5'd13, 5'd14, 5'd15}));
    check("t3_heading", 40'(heading), 40'd0);
    check("t3_len", 40'(length), 40'd3);

    // right wall at (23,5)
    do_reset();
    for (int i = 0; i < 11; i++) do_step(2'd0, 1'b0);
    for (int i = 0; i < 7; i++) do_step(2'd1, 1'b0);
    check_head("t4_pre", 5'd23, 5'd5);
    check("t4_heading_pre", 40'(heading), 40'd1);
    do_step(2'd0, 1'b0);
`ifdef SNAKE_WRAP_EN
    check_head("t4_wrap", 5'd0, 5'd5);
    check("t4_dead", 40'(dead), 40'd0);
    check("t4_heading", 40'(heading), 40'd0);
`else
    check_head("t4_wall", 5'd23, 5'd5);
    check("t4_dead", 40'(dead), 40'd1);
    check("t4_heading", 40'(heading), 40'd1);
    do_step(2'd3, 1'b1);
    check_head("t4_frozen", 5'd23, 5'd5);
    check("t4_frozen_len", 40'(length), 40'd1);
    check("t4_still_dead", 40'(dead), 40'd1);
`endif

    // left wall: x = -1
    do_reset();
    for (int i = 0; i < 13; i++) do_step(2'd2, 1'b0);
`ifdef SNAKE_WRAP_EN
    check_head("t4l_wrap", 5'd23, 5'd12);
    check("t4l_dead", 40'(dead), 40'd0);
`else
    check_head("t4l_wall", 5'd0, 5'd12);
    check("t4l_dead", 40'(dead), 40'd1);
`endif

    // length 5 turning R,U,L,D into its own body
    do_reset();
    for (int i = 0; i < 4; i++) do_grow();
    for (int i = 0; i < 4; i++) do_step(2'd0, 1'b0);
    check("t5_len5", 40'(length), 40'd5);
    check("t5_segx", seg_x, 40'({5'd12, 5'd13, 5'd14, 5'd15, 5'd16}));
    do_step(2'd3, 1'b0);
    do_step(2'd2, 1'b0);
    check("t5_alive", 40'(dead), 40'd0);
    do_step(2'd1, 1'b0);
    check("t5_dead", 40'(dead), 40'd1);
    check_head("t5_frozen", 5'd15, 5'd13);
    check("t5_len", 40'(length), 40'd5);
    check("t5_heading", 40'(heading), 40'd2);

    // tail chasing around a 2x2 loop at length 4
    do_reset();
    for (int i = 0; i < 3; i++) do_grow();
    do_step(2'd0, 1'b0);
    do_step(2'd3, 1'b0);
    do_step(2'd2, 1'b0);
    check("t5t_len4", 40'(length), 40'd4);
    do_step(2'd1, 1'b0);
    check("t5t_dead1", 40'(dead), 40'd0);
    check_head("t5t_h1", 5'd12, 5'd12);
    do_step(2'd0, 1'b0);
    check("t5t_dead2", 40'(dead), 40'd0);
    check_head("t5t_h2", 5'd13, 5'd12);
    check("t5t_segy", seg_y, 40'({5'd13, 5'd13, 5'd12, 5'd12}));
    // growing keeps the tail in place, so the same move now collides
    do_step(2'd3, 1'b1);
    check("t5t_grow_dead", 40'(dead), 40'd1);
    check("t5t_grow_len", 40'(length), 40'd4);

    // saturation at MAX_LEN
    do_reset();
    for (int i = 0; i < 10; i++) do_grow();
    for (int i = 0; i < 7; i++) do_step(2'd0, 1'b0);
    check("t6_len_full", 40'(length), 40'd8);
    for (int i = 0; i < 3; i++) do_step(2'd0, 1'b0);
    check("t6_len_sat", 40'(length), 40'd8);
    check("t6_segx", seg_x,
          40'({5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22}));

    // reset in the middle of growth drops the pending grows
    do_reset();
    for (int i = 0; i < 5; i++) do_grow();
    do_step(2'd0, 1'b0);
    do_step(2'd0, 1'b0);
    check("t6_mid_len", 40'(length), 40'd3);
    do_reset();
    check("t6_rst_len", 40'(length), 40'd1);
    do_step(2'd0, 1'b0);
    do_step(2'd0, 1'b0);
    check("t6_nopend_len", 40'(length), 40'd1);
    check("t6_nopend_segx", seg_x, 40'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
